// File: rtl/uimac_rx_filter.sv
// MAC receive front end: parses the 14-byte header, filters on address/type,
// extracts pause quanta and buffers accepted payloads store-and-forward.
module uimac_rx_filter #(
    parameter int NUM_ADDR = 2,
    parameter int DATA_AW  = 12,
    parameter int INFO_AW  = 4,
    parameter int MAX_LEN  = 1500
) (
    input  logic                    I_clk,
    input  logic                    I_reset_n,
    input  logic [48*NUM_ADDR-1:0]  I_mac_addr_tbl,
    input  logic [NUM_ADDR-1:0]     I_addr_en,
    input  logic                    I_promisc,
    input  logic                    I_crc_chk_en,
    input  logic                    I_rx_valid,
    input  logic [7:0]              I_rx_data,
    input  logic                    I_rx_last,
    input  logic                    I_rx_err,
    output logic                    O_m_valid,
    output logic [7:0]              O_m_data,
    output logic                    O_m_last,
    output logic [15:0]             O_m_type,
    output logic [10:0]             O_m_len,
    input  logic                    I_m_ready,
    output logic                    O_pause_en,
    output logic [15:0]             O_pause_quanta,
    output logic [47:0]             O_pause_addr,
    output logic [15:0]             O_drop_cnt,
    output logic [15:0]             O_ovf_cnt
);
    localparam logic [DATA_AW:0] BUF_FULL  = {1'b1, {DATA_AW{1'b0}}};
    localparam logic [INFO_AW:0] INFO_FULL = {1'b1, {INFO_AW{1'b0}}};
    localparam logic [DATA_AW:0] PTR_ONE   = 1;
    localparam logic [INFO_AW:0] IPTR_ONE  = 1;
    localparam logic [10:0]      LEN_MAX   = 11'(MAX_LEN);

    typedef enum logic [1:0] {W_HDR, W_PAYLOAD, W_PAUSE, W_DROP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} rstate_t;

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;

    logic [103:0] hdr;
    logic [111:0] hdr_full;
    logic [47:0]  dst;
    logic [15:0]  rx_type;
    logic [3:0]   hdr_cnt;
    logic [10:0]  len;
    logic         ovf_flag;
    logic [2:0]   pcnt;
    logic [31:0]  pq, pause_word;
    logic         pause_ok;

    logic [DATA_AW:0] wr_ptr, committed_wr, rd_ptr, rd_next;
    logic [INFO_AW:0] iw_ptr, ir_ptr;
    logic [7:0]       mem [2**DATA_AW];
    logic [26:0]      info_mem [2**INFO_AW];
    logic [26:0]      info_q;
    logic [10:0]      byte_cnt;

    logic buf_full, info_full, info_empty, rx_bad;
    logic ucast_hit, bcast, pause_dst, accept;
    logic do_write, do_commit, do_rollback, inc_drop, inc_ovf, set_ovf, pause_fire;
    logic pop, xfer;

    // The header shifts in MSB first; once byte 13 lands, hdr holds src and type.
    assign hdr_full   = {hdr, I_rx_data};
    assign dst        = hdr_full[111:64];
    assign rx_type    = hdr_full[15:0];
    assign rx_bad     = I_rx_err & I_crc_chk_en;
    assign buf_full   = ((wr_ptr - rd_ptr) == BUF_FULL);
    assign info_full  = ((iw_ptr - ir_ptr) == INFO_FULL);
    assign info_empty = (iw_ptr == ir_ptr);
    assign rd_next    = rd_ptr + PTR_ONE;

    always_comb begin
        ucast_hit = 1'b0;
        for (int k = 0; k < NUM_ADDR; k++) begin
            if (I_addr_en[k] && (I_mac_addr_tbl[48*k +: 48] == dst)) ucast_hit = 1'b1;
        end
    end

    assign bcast     = (dst == 48'hFFFF_FFFF_FFFF);
    assign pause_dst = (dst == 48'h0180_C200_0001) && (rx_type == 16'h8808);
    assign accept    = I_promisc
                     | (ucast_hit & ((rx_type == 16'h0800) | (rx_type == 16'h0806)))
                     | (bcast & (rx_type == 16'h0806));

    // Opcode and quanta form a 32-bit word; the final byte may still be on the bus.
    assign pause_word = (pcnt >= 3'd4) ? pq : {pq[23:0], I_rx_data};
    assign pause_ok   = (pcnt >= 3'd3) && (pause_word[31:16] == 16'h0001) && !rx_bad;

    always_comb begin
        w_next      = w_state;
        do_write    = 1'b0;
        do_commit   = 1'b0;
        do_rollback = 1'b0;
        inc_drop    = 1'b0;
        inc_ovf     = 1'b0;
        set_ovf     = 1'b0;
        pause_fire  = 1'b0;
        case (w_state)
            W_HDR: if (I_rx_valid) begin
                if (hdr_cnt == 4'd13) begin
                    if (I_rx_last) inc_drop = accept || !pause_dst;
                    else if (accept) w_next = W_PAYLOAD;
                    else if (pause_dst) w_next = W_PAUSE;
                    else w_next = W_DROP;
                end else if (I_rx_last) begin
                    inc_drop = 1'b1;
                end
            end
            W_PAYLOAD: if (I_rx_valid) begin
                if (buf_full) begin
                    do_rollback = 1'b1;
                    set_ovf     = !I_rx_last;
                    inc_ovf     = I_rx_last;
                    w_next      = I_rx_last ? W_HDR : W_DROP;
                end else if (len == LEN_MAX) begin
                    do_rollback = 1'b1;
                    inc_drop    = I_rx_last;
                    w_next      = I_rx_last ? W_HDR : W_DROP;
                end else begin
                    do_write = 1'b1;
                    if (I_rx_last) begin
                        w_next = W_HDR;
                        if (!rx_bad && !info_full) begin
                            do_commit = 1'b1;
                        end else begin
                            do_rollback = 1'b1;
                            inc_drop    = rx_bad;
                            inc_ovf     = !rx_bad;
                        end
                    end
                end
            end
            W_PAUSE: if (I_rx_valid && I_rx_last) begin
                pause_fire = pause_ok;
                w_next     = W_HDR;
            end
            W_DROP: if (I_rx_valid && I_rx_last) begin
                inc_ovf  = ovf_flag;
                inc_drop = !ovf_flag;
                w_next   = W_HDR;
            end
            default: w_next = W_HDR;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            w_state        <= W_HDR;
            hdr            <= '0;
            hdr_cnt        <= '0;
            len            <= '0;
            ovf_flag       <= 1'b0;
            pcnt           <= '0;
            pq             <= '0;
            wr_ptr         <= '0;
            committed_wr   <= '0;
            iw_ptr         <= '0;
            O_pause_en     <= 1'b0;
            O_pause_quanta <= '0;
            O_pause_addr   <= '0;
            O_drop_cnt     <= '0;
            O_ovf_cnt      <= '0;
        end else begin
            w_state    <= w_next;
            O_pause_en <= pause_fire;
            if (I_rx_valid && w_state == W_HDR) begin
                hdr     <= hdr_full[103:0];
                hdr_cnt <= (I_rx_last || hdr_cnt == 4'd13) ? 4'd0 : hdr_cnt + 4'd1;
            end
            if (w_state == W_HDR) begin
                len      <= '0;
                pcnt     <= '0;
                ovf_flag <= 1'b0;
            end
            if (do_write) len <= len + 11'd1;
            if (set_ovf) ovf_flag <= 1'b1;
            if (I_rx_valid && w_state == W_PAUSE && pcnt < 3'd4) begin
                pq   <= {pq[23:0], I_rx_data};
                pcnt <= pcnt + 3'd1;
            end
            if (pause_fire) begin
                O_pause_quanta <= pause_word[15:0];
                O_pause_addr   <= hdr[63:16];
            end
            if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_commit) begin
                committed_wr <= wr_ptr + PTR_ONE;
                iw_ptr       <= iw_ptr + IPTR_ONE;
            end
            if (do_rollback) wr_ptr <= committed_wr;
            if (inc_drop && O_drop_cnt != 16'hFFFF) O_drop_cnt <= O_drop_cnt + 16'd1;
            if (inc_ovf && O_ovf_cnt != 16'hFFFF) O_ovf_cnt <= O_ovf_cnt + 16'd1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (do_write) mem[wr_ptr[DATA_AW-1:0]] <= I_rx_data;
        if (do_commit) info_mem[iw_ptr[INFO_AW-1:0]] <= {len + 11'd1, hdr[15:0]};
    end

    // Output handshake: a byte moves on a cycle with O_m_valid && I_m_ready; while
    // valid is high and ready low, data, last, type and len hold and valid stays up.
    always_comb begin
        r_next    = r_state;
        pop       = 1'b0;
        xfer      = 1'b0;
        O_m_valid = 1'b0;
        O_m_last  = 1'b0;
        case (r_state)
            R_IDLE: if (!info_empty) begin
                pop    = 1'b1;
                r_next = R_LOAD;
            end
            R_LOAD: r_next = R_SEND;
            R_SEND: begin
                O_m_valid = 1'b1;
                O_m_last  = (byte_cnt == O_m_len);
                xfer      = I_m_ready;
                if (I_m_ready && O_m_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_state  <= R_IDLE;
            ir_ptr   <= '0;
            rd_ptr   <= '0;
            info_q   <= '0;
            byte_cnt <= '0;
            O_m_data <= '0;
            O_m_type <= '0;
            O_m_len  <= '0;
        end else begin
            r_state <= r_next;
            if (pop) begin
                info_q <= info_mem[ir_ptr[INFO_AW-1:0]];
                ir_ptr <= ir_ptr + IPTR_ONE;
            end
            if (r_state == R_LOAD) begin
                O_m_len  <= info_q[26:16];
                O_m_type <= info_q[15:0];
                O_m_data <= mem[rd_ptr[DATA_AW-1:0]];
                byte_cnt <= 11'd1;
            end
            if (xfer) begin
                rd_ptr <= rd_next;
                if (!O_m_last) begin
                    byte_cnt <= byte_cnt + 11'd1;
                    O_m_data <= mem[rd_next[DATA_AW-1:0]];
                end
            end
        end
    end
endmodule

// File: tb/tb_uimac_rx_filter.sv
// Bench for uimac_rx_filter: payload scoreboard, pause and counter checks,
// buffer/info-FIFO overflow, length boundaries and mid-frame reset.
`timescale 1ns/1ps
module tb_uimac_rx_filter;
    localparam int NUM_ADDR = 2;
    localparam int DATA_AW  = 6;
    localparam int INFO_AW  = 2;
    localparam int MAX_LEN  = 60;

    localparam logic [47:0] MAC0     = 48'h0200_0000_0001;
    localparam logic [47:0] MAC1     = 48'h0200_0000_0002;
    localparam logic [47:0] BCAST    = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] PAUSE_DA = 48'h0180_C200_0001;
    localparam logic [47:0] OTHER_DA = 48'h0A0B_0C0D_0E0F;

    logic                   clk;
    logic                   rst_n;
    logic [48*NUM_ADDR-1:0] mac_tbl;
    logic [NUM_ADDR-1:0]    addr_en;
    logic                   promisc;
    logic                   crc_en;
    logic                   rx_valid;
    logic [7:0]             rx_data;
    logic                   rx_last;
    logic                   rx_err;
    logic                   m_valid;
    logic [7:0]             m_data;
    logic                   m_last;
    logic [15:0]            m_type;
    logic [10:0]            m_len;
    logic                   m_ready;
    logic                   pause_en;
    logic [15:0]            pause_quanta;
    logic [47:0]            pause_addr;
    logic [15:0]            drop_cnt;
    logic [15:0]            ovf_cnt;

    uimac_rx_filter #(
        .NUM_ADDR(NUM_ADDR), .DATA_AW(DATA_AW), .INFO_AW(INFO_AW), .MAX_LEN(MAX_LEN)
    ) dut (
        .I_clk(clk), .I_reset_n(rst_n), .I_mac_addr_tbl(mac_tbl), .I_addr_en(addr_en),
        .I_promisc(promisc), .I_crc_chk_en(crc_en), .I_rx_valid(rx_valid),
        .I_rx_data(rx_data), .I_rx_last(rx_last), .I_rx_err(rx_err),
        .O_m_valid(m_valid), .O_m_data(m_data), .O_m_last(m_last), .O_m_type(m_type),
        .O_m_len(m_len), .I_m_ready(m_ready), .O_pause_en(pause_en),
        .O_pause_quanta(pause_quanta), .O_pause_addr(pause_addr),
        .O_drop_cnt(drop_cnt), .O_ovf_cnt(ovf_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- shared state ----------------
    logic [35:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_drop = 0;
    int          exp_ovf  = 0;
    int          pause_seen = 0;
    logic [15:0] seen_quanta = '0;
    logic [47:0] seen_addr = '0;
    logic [7:0]  fb [0:127];
    logic [47:0] src_a = 48'h0A1B_2C3D_4E5F;
    int          ready_mode = 0;
    bit          hold_v = 0;
    logic [35:0] hold_beat = '0;
    logic [35:0] beat;
    logic [35:0] exp_beat;
    bit          prev_pause = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- consumer ready ----------------
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 2) m_ready = 1'($urandom_range(0, 1));
            else m_ready = (ready_mode == 1);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v     = 0;
                prev_pause = 0;
            end else begin
                beat = {m_last, m_type, m_len, m_data};
                if (hold_v) begin
                    check("valid_held", {63'd0, m_valid}, 64'd1);
                    if (m_valid) check("stable_while_stalled", {28'd0, beat}, {28'd0, hold_beat});
                end
                if (m_valid && m_ready) begin
                    check("beat_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                    if (exp_q.size() != 0) begin
                        exp_beat = exp_q.pop_front();
                        check("m_beat", {28'd0, beat}, {28'd0, exp_beat});
                    end
                end
                hold_v    = m_valid && !m_ready;
                hold_beat = beat;
                if (pause_en) begin
                    check("pause_single_cycle", {63'd0, prev_pause}, 64'd0);
                    pause_seen++;
                    seen_quanta = pause_quanta;
                    seen_addr   = pause_addr;
                end
                prev_pause = pause_en;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic build(input logic [47:0] dst, input logic [47:0] src,
                         input logic [15:0] typ, input int plen);
        for (int i = 0; i < 6; i++) begin
            fb[i]     = dst[47-8*i -: 8];
            fb[6 + i] = src[47-8*i -: 8];
        end
        fb[12] = typ[15:8];
        fb[13] = typ[7:0];
        for (int i = 0; i < plen; i++) fb[14 + i] = 8'($urandom_range(0, 255));
    endtask

    task automatic drive(input int n, input bit err, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                rx_valid = 1'b0;
                rx_last  = 1'b0;
                rx_err   = 1'b0;
            end
            @(posedge clk);
            #1;
            rx_valid = 1'b1;
            rx_data  = fb[i];
            rx_last  = (i == n - 1);
            rx_err   = (i == n - 1) ? err : 1'b0;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic expect_payload(input logic [15:0] typ, input int plen);
        for (int i = 0; i < plen; i++)
            exp_q.push_back({(i == plen - 1), typ, 11'(plen), fb[14 + i]});
    endtask

    task automatic send(input logic [47:0] dst, input logic [15:0] typ, input int plen,
                        input bit err, input bit deliver);
        build(dst, src_a, typ, plen);
        if (deliver) expect_payload(typ, plen);
        drive(14 + plen, err, 1'b1);
    endtask

    task automatic settle(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        repeat (8) @(posedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_counters();
        check("drop_cnt", {48'd0, drop_cnt}, 64'(exp_drop));
        check("ovf_cnt", {48'd0, ovf_cnt}, 64'(exp_ovf));
    endtask

    task automatic check_reset_state();
        check("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_m_beat", {28'd0, m_last, m_type, m_len, m_data}, 64'd0);
        check("rst_pause_en", {63'd0, pause_en}, 64'd0);
        check("rst_pause_quanta", {48'd0, pause_quanta}, 64'd0);
        check("rst_pause_addr", {16'd0, pause_addr}, 64'd0);
        check("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
        check("rst_ovf_cnt", {48'd0, ovf_cnt}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int plen;
        rst_n    = 1'b0;
        mac_tbl  = {MAC1, MAC0};
        addr_en  = 2'b11;
        promisc  = 1'b0;
        crc_en   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        rx_last  = 1'b0;
        rx_err   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst_n      = 1'b1;
        ready_mode = 1;
        repeat (2) @(posedge clk);

        // unicast to enabled entry 1, then broadcast filtering
        send(MAC1, 16'h0800, 46, 1'b0, 1'b1);
        settle(2000);
        check_counters();
        send(BCAST, 16'h0800, 46, 1'b0, 1'b0);
        exp_drop++;
        send(BCAST, 16'h0806, 28, 1'b0, 1'b1);
        settle(2000);
        check_counters();

        // errored frames with and without CRC checking
        crc_en = 1'b1;
        send(MAC0, 16'h0800, 30, 1'b1, 1'b0);
        exp_drop++;
        send(MAC0, 16'h0806, 20, 1'b0, 1'b1);
        settle(2000);
        check_counters();
        crc_en = 1'b0;
        send(MAC0, 16'h0800, 30, 1'b1, 1'b1);
        settle(2000);
        crc_en = 1'b1;
        check_counters();

        // pause frames: good, bad opcode, too short, exactly four bytes
        base = pause_seen;
        build(PAUSE_DA, 48'h1122_3344_5566, 16'h8808, 46);
        fb[14] = 8'h00; fb[15] = 8'h01; fb[16] = 8'h00; fb[17] = 8'hFF;
        drive(60, 1'b0, 1'b0);
        settle(100);
        check("pause_count_good", 64'(pause_seen - base), 64'd1);
        check("pause_quanta_seen", {48'd0, seen_quanta}, 64'h00FF);
        check("pause_addr_seen", {16'd0, seen_addr}, 64'h1122_3344_5566);
        fb[15] = 8'h02; fb[16] = 8'h12; fb[17] = 8'h34;
        drive(60, 1'b0, 1'b0);
        settle(100);
        check("pause_count_badop", 64'(pause_seen - base), 64'd1);
        check("pause_quanta_held", {48'd0, pause_quanta}, 64'h00FF);
        fb[15] = 8'h01;
        drive(17, 1'b0, 1'b0);
        settle(100);
        check("pause_count_short", 64'(pause_seen - base), 64'd1);
        build(PAUSE_DA, 48'h6655_4433_2211, 16'h8808, 4);
        fb[14] = 8'h00; fb[15] = 8'h01; fb[16] = 8'h0A; fb[17] = 8'hBC;
        drive(18, 1'b0, 1'b1);
        settle(100);
        check("pause_count_min", 64'(pause_seen - base), 64'd2);
        check("pause_quanta_min", {48'd0, pause_quanta}, 64'h0ABC);
        check("pause_addr_min", {16'd0, pause_addr}, 64'h6655_4433_2211);
        check_counters();

        // disabled table entry, promiscuous mode
        addr_en = 2'b01;
        send(MAC1, 16'h0800, 20, 1'b0, 1'b0);
        exp_drop++;
        addr_en = 2'b11;
        promisc = 1'b1;
        send(OTHER_DA, 16'h1234, 10, 1'b0, 1'b1);
        settle(2000);
        promisc = 1'b0;
        check_counters();

        // random consumer back-pressure
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            plen = $urandom_range(1, MAX_LEN);
            send(($urandom_range(0, 1) != 0) ? MAC0 : MAC1,
                 ($urandom_range(0, 1) != 0) ? 16'h0800 : 16'h0806, plen, 1'b0, 1'b1);
            settle(4000);
        end
        ready_mode = 1;

        // length boundaries
        send(MAC0, 16'h0800, MAX_LEN, 1'b0, 1'b1);
        settle(2000);
        send(MAC0, 16'h0800, MAX_LEN + 1, 1'b0, 1'b0);
        exp_drop++;
        settle(2000);
        send(MAC0, 16'h0806, 1, 1'b0, 1'b1);
        settle(2000);
        check_counters();

        // payload buffer overflow with the consumer stalled
        ready_mode = 0;
        repeat (2) @(posedge clk);
        send(MAC0, 16'h0800, 40, 1'b0, 1'b1);
        send(MAC0, 16'h0800, 40, 1'b0, 1'b0);
        exp_ovf++;
        send(MAC0, 16'h0800, 40, 1'b0, 1'b0);
        exp_ovf++;
        repeat (8) @(posedge clk);
        check_counters();
        ready_mode = 1;
        settle(2000);
        send(MAC1, 16'h0806, 40, 1'b0, 1'b1);
        settle(2000);
        check_counters();

        // frame-info FIFO overflow
        ready_mode = 0;
        repeat (2) @(posedge clk);
        for (int f = 0; f < 5; f++) send(MAC0, 16'h0800, 1, 1'b0, 1'b1);
        send(MAC0, 16'h0800, 1, 1'b0, 1'b0);
        exp_ovf++;
        repeat (8) @(posedge clk);
        check_counters();
        ready_mode = 1;
        settle(2000);

        // runt, zero-length frame, zero-length pause frame
        base = pause_seen;
        build(MAC0, src_a, 16'h0800, 0);
        drive(10, 1'b0, 1'b1);
        exp_drop++;
        drive(14, 1'b0, 1'b1);
        exp_drop++;
        build(PAUSE_DA, src_a, 16'h8808, 0);
        drive(14, 1'b0, 1'b0);
        settle(100);
        check_counters();
        check("pause_count_runt", 64'(pause_seen - base), 64'd0);

        // reset in the middle of a payload
        build(MAC0, src_a, 16'h0800, 40);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            rx_valid = 1'b1;
            rx_data  = fb[i];
            rx_last  = 1'b0;
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        exp_drop = 0;
        exp_ovf  = 0;
        rst_n    = 1'b1;
        repeat (2) @(posedge clk);
        send(MAC1, 16'h0800, 46, 1'b0, 1'b1);
        settle(2000);
        check_counters();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
